// File: rtl/sa_write_channel.sv
// sa_write_channel: N-to-1 AXI write-channel arbiter.
// AW is arbitrated round-robin and the grant is locked while the slave stalls.
// Each accepted AW pushes its master index into a W-order FIFO.
// The FIFO head selects which master's W beats reach the slave, and WLAST pops it.
// B responses are steered back by the master index carried in the upper BID bits.
module sa_write_channel #(
    parameter int MST_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int TRANS_WR_RESP_W   = 2,
    parameter int MST_ID_W          = $clog2(MST_AMT)
) (
    input  logic                                   ACLK_i,
    input  logic                                   ARESETn_i,
    // dispatcher AW
    input  logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_AWID_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]          dsp_AWADDR_i,
    input  logic [TRANS_BURST_W*MST_AMT-1:0]       dsp_AWBURST_i,
    input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]    dsp_AWLEN_i,
    input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]   dsp_AWSIZE_i,
    input  logic [MST_AMT-1:0]                     dsp_AWVALID_i,
    input  logic [MST_AMT-1:0]                     dsp_AW_outst_full_i,
    output logic [MST_AMT-1:0]                     dsp_AWREADY_o,
    // dispatcher W
    input  logic [DATA_WIDTH*MST_AMT-1:0]          dsp_WDATA_i,
    input  logic [MST_AMT-1:0]                     dsp_WLAST_i,
    input  logic [MST_AMT-1:0]                     dsp_WVALID_i,
    output logic [MST_AMT-1:0]                     dsp_WREADY_o,
    // dispatcher B
    output logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_BID_o,
    output logic [TRANS_WR_RESP_W*MST_AMT-1:0]     dsp_BRESP_o,
    output logic [MST_AMT-1:0]                     dsp_BVALID_o,
    input  logic [MST_AMT-1:0]                     dsp_BREADY_i,
    // slave AW
    output logic [TRANS_MST_ID_W+MST_ID_W-1:0]     s_AWID_o,
    output logic [ADDR_WIDTH-1:0]                  s_AWADDR_o,
    output logic [TRANS_BURST_W-1:0]               s_AWBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]            s_AWLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]           s_AWSIZE_o,
    output logic                                   s_AWVALID_o,
    input  logic                                   s_AWREADY_i,
    // slave W
    output logic [DATA_WIDTH-1:0]                  s_WDATA_o,
    output logic                                   s_WLAST_o,
    output logic                                   s_WVALID_o,
    input  logic                                   s_WREADY_i,
    // slave B
    input  logic [TRANS_MST_ID_W+MST_ID_W-1:0]     s_BID_i,
    input  logic [TRANS_WR_RESP_W-1:0]             s_BRESP_i,
    input  logic                                   s_BVALID_i,
    output logic                                   s_BREADY_o
);

    localparam int  EXT_ID_W       = TRANS_MST_ID_W + MST_ID_W;
    localparam int  PTR_W          = $clog2(OUTSTANDING_AMT);
    localparam bool_t_dummy        = 0;
    localparam bit  B_ALL_IN_RANGE = (MST_AMT == (1 << MST_ID_W));

    // Round-robin search starting at ptr; returns {found, index}.
    function automatic logic [MST_ID_W:0] rr_pick(input logic [MST_AMT-1:0]  req,
                                                  input logic [MST_ID_W-1:0] ptr);
        logic                found;
        logic [MST_ID_W-1:0] idx;
        logic [MST_ID_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            cand = MST_ID_W'((int'(ptr) + i) % MST_AMT);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // Per-master views of the flattened payload buses.
    logic [TRANS_MST_ID_W-1:0]    w_awid    [MST_AMT];
    logic [ADDR_WIDTH-1:0]        w_awaddr  [MST_AMT];
    logic [TRANS_BURST_W-1:0]     w_awburst [MST_AMT];
    logic [TRANS_DATA_LEN_W-1:0]  w_awlen   [MST_AMT];
    logic [TRANS_DATA_SIZE_W-1:0] w_awsize  [MST_AMT];
    logic [DATA_WIDTH-1:0]        w_wdata   [MST_AMT];

    for (genvar k = 0; k < MST_AMT; k++) begin : g_unpack
        assign w_awid[k]    = dsp_AWID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        assign w_awaddr[k]  = dsp_AWADDR_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_awburst[k] = dsp_AWBURST_i[k*TRANS_BURST_W +: TRANS_BURST_W];
        assign w_awlen[k]   = dsp_AWLEN_i[k*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        assign w_awsize[k]  = dsp_AWSIZE_i[k*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
        assign w_wdata[k]   = dsp_WDATA_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // State
    logic [MST_ID_W-1:0] r_rr_ptr;
    logic                r_lock;
    logic [MST_ID_W-1:0] r_lock_idx;
    logic [MST_ID_W-1:0] r_fifo [OUTSTANDING_AMT];
    logic [PTR_W:0]      r_wr_ptr;
    logic [PTR_W:0]      r_rd_ptr;

    logic [MST_AMT-1:0]  w_req;
    logic [MST_ID_W:0]   w_rr_result;
    logic                w_rr_found;
    logic [MST_ID_W-1:0] w_rr_idx;
    logic [MST_ID_W-1:0] w_grant;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_aw_hs;
    logic [MST_ID_W-1:0] w_head;
    logic                w_pop;

    // AW arbitration: a locked grant overrides the round-robin choice.
    assign w_req        = dsp_AWVALID_i & ~dsp_AW_outst_full_i;
    assign w_rr_result  = rr_pick(w_req, r_rr_ptr);
    assign w_rr_found   = w_rr_result[MST_ID_W];
    assign w_rr_idx     = w_rr_result[MST_ID_W-1:0];
    assign w_grant      = r_lock ? r_lock_idx : w_rr_idx;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                          (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    // Full blocks AW regardless of a same-cycle pop, keeping the path free of W timing.
    assign s_AWVALID_o  = ARESETn_i & ~w_fifo_full & (r_lock | w_rr_found);
    assign w_aw_hs      = s_AWVALID_o & s_AWREADY_i;

    assign s_AWID_o     = {w_grant, w_awid[w_grant]};
    assign s_AWADDR_o   = w_awaddr[w_grant];
    assign s_AWBURST_o  = w_awburst[w_grant];
    assign s_AWLEN_o    = w_awlen[w_grant];
    assign s_AWSIZE_o   = w_awsize[w_grant];

    // AW ready is returned only to the granted master.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dsp_AWREADY_o          = '0;
        dsp_AWREADY_o[w_grant] = w_aw_hs;
    end

    // W routing from the FIFO head; everything is gated low while the FIFO is empty.
    assign w_head     = r_fifo[r_rd_ptr[PTR_W-1:0]];
    assign s_WVALID_o = ~w_fifo_empty & dsp_WVALID_i[w_head];
    assign s_WDATA_o  = w_fifo_empty ? '0 : w_wdata[w_head];
    assign s_WLAST_o  = ~w_fifo_empty & dsp_WLAST_i[w_head];
    assign w_pop      = s_WVALID_o & s_WREADY_i & s_WLAST_o;

    // W ready is returned only to the head master.
    always_comb begin
        dsp_WREADY_o         = '0;
        dsp_WREADY_o[w_head] = ~w_fifo_empty & s_WREADY_i;
    end

    // B routing by the master index in the upper BID bits.
    logic [MST_ID_W-1:0] w_b_mst;
    logic                w_b_in_range;

    assign w_b_mst = s_BID_i[EXT_ID_W-1:TRANS_MST_ID_W];

    if (B_ALL_IN_RANGE) begin : g_b_full_range
        assign w_b_in_range = 1'b1;
    end else begin : g_b_part_range
        assign w_b_in_range = (w_b_mst < MST_ID_W'(MST_AMT));
    end

    assign dsp_BID_o   = {MST_AMT{s_BID_i[TRANS_MST_ID_W-1:0]}};
    assign dsp_BRESP_o = {MST_AMT{s_BRESP_i}};

    // Steer BVALID to the addressed master; out-of-range responses are drained.
    always_comb begin
        dsp_BVALID_o = '0;
        s_BREADY_o   = 1'b1;
        if (w_b_in_range) begin
            dsp_BVALID_o[w_b_mst] = s_BVALID_i;
            s_BREADY_o            = dsp_BREADY_i[w_b_mst];
        end
    end

    // Grant lock while stalled and round-robin pointer advance on handshake.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
        end else if (w_aw_hs) begin
            r_lock   <= 1'b0;
            r_rr_ptr <= (w_grant == MST_ID_W'(MST_AMT - 1)) ? '0 : w_grant + 1'b1;
        end else if (s_AWVALID_o) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_grant;
        end
    end

    // W-order FIFO pointers; push on AW handshake, pop on the last W beat.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_aw_hs) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // W-order FIFO storage.
    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge ACLK_i) begin
        if (w_aw_hs) r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_grant;
    end

endmodule

// File: tb/tb_sa_write_channel.sv
// Testbench for sa_write_channel: directed scenarios followed by a randomized
// run checked by a scoreboard against a transaction-level reference model.
module tb_sa_write_channel;

    localparam int MST   = 2;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int IDW   = 5;
    localparam int XW    = IDW + 1;
    localparam int NTX   = 24;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;

    logic [IDW*MST-1:0]   dsp_AWID_i;
    logic [AW*MST-1:0]    dsp_AWADDR_i;
    logic [2*MST-1:0]     dsp_AWBURST_i;
    logic [3*MST-1:0]     dsp_AWLEN_i;
    logic [3*MST-1:0]     dsp_AWSIZE_i;
    logic [MST-1:0]       dsp_AWVALID_i;
    logic [MST-1:0]       dsp_AW_outst_full_i;
    logic [MST-1:0]       dsp_AWREADY_o;
    logic [DW*MST-1:0]    dsp_WDATA_i;
    logic [MST-1:0]       dsp_WLAST_i;
    logic [MST-1:0]       dsp_WVALID_i;
    logic [MST-1:0]       dsp_WREADY_o;
    logic [IDW*MST-1:0]   dsp_BID_o;
    logic [2*MST-1:0]     dsp_BRESP_o;
    logic [MST-1:0]       dsp_BVALID_o;
    logic [MST-1:0]       dsp_BREADY_i;
    logic [XW-1:0]        s_AWID_o;
    logic [AW-1:0]        s_AWADDR_o;
    logic [1:0]           s_AWBURST_o;
    logic [2:0]           s_AWLEN_o;
    logic [2:0]           s_AWSIZE_o;
    logic                 s_AWVALID_o;
    logic                 s_AWREADY_i;
    logic [DW-1:0]        s_WDATA_o;
    logic                 s_WLAST_o;
    logic                 s_WVALID_o;
    logic                 s_WREADY_i;
    logic [XW-1:0]        s_BID_i;
    logic [1:0]           s_BRESP_i;
    logic                 s_BVALID_i;
    logic                 s_BREADY_o;

    always #5 clk = ~clk;

    sa_write_channel #(
        .MST_AMT(MST), .OUTSTANDING_AMT(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .TRANS_MST_ID_W(IDW)
    ) dut (
        .ACLK_i(clk), .ARESETn_i(rst_n),
        .dsp_AWID_i(dsp_AWID_i), .dsp_AWADDR_i(dsp_AWADDR_i), .dsp_AWBURST_i(dsp_AWBURST_i),
        .dsp_AWLEN_i(dsp_AWLEN_i), .dsp_AWSIZE_i(dsp_AWSIZE_i), .dsp_AWVALID_i(dsp_AWVALID_i),
        .dsp_AW_outst_full_i(dsp_AW_outst_full_i), .dsp_AWREADY_o(dsp_AWREADY_o),
        .dsp_WDATA_i(dsp_WDATA_i), .dsp_WLAST_i(dsp_WLAST_i), .dsp_WVALID_i(dsp_WVALID_i),
        .dsp_WREADY_o(dsp_WREADY_o),
        .dsp_BID_o(dsp_BID_o), .dsp_BRESP_o(dsp_BRESP_o), .dsp_BVALID_o(dsp_BVALID_o),
        .dsp_BREADY_i(dsp_BREADY_i),
        .s_AWID_o(s_AWID_o), .s_AWADDR_o(s_AWADDR_o), .s_AWBURST_o(s_AWBURST_o),
        .s_AWLEN_o(s_AWLEN_o), .s_AWSIZE_o(s_AWSIZE_o), .s_AWVALID_o(s_AWVALID_o),
        .s_AWREADY_i(s_AWREADY_i),
        .s_WDATA_o(s_WDATA_o), .s_WLAST_o(s_WLAST_o), .s_WVALID_o(s_WVALID_o),
        .s_WREADY_i(s_WREADY_i),
        .s_BID_i(s_BID_i), .s_BRESP_i(s_BRESP_i), .s_BVALID_i(s_BVALID_i), .s_BREADY_o(s_BREADY_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Randomized transaction set per dispatcher.
    logic [IDW-1:0] tx_id   [MST][NTX];
    logic [AW-1:0]  tx_addr [MST][NTX];
    logic [2:0]     tx_len  [MST][NTX];
    logic [2:0]     tx_size [MST][NTX];
    logic [DW-1:0]  tx_base [MST][NTX];
    int             aw_i [MST];
    int             w_i  [MST];
    int             w_b  [MST];

    // Reference model state, advanced by the monitor.
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t          sb_q[$];
    int             order_q[$];
    int             m_ptr;
    bit             m_lock;
    int             m_lock_idx;
    bit             mon_en = 1'b0;
    logic [MST-1:0] aw_hs_seen = '0;
    logic [MST-1:0] w_hs_seen  = '0;

    // Monitor: compares DUT outputs with the reference model every cycle.
    always @(negedge clk) begin : monitor
        logic [MST-1:0] req;
        logic [MST-1:0] exp_rdy;
        int             g;
        int             c;
        int             h;
        int             m;
        int             ti;
        bit             found;
        bit             exp_awv;
        bit             exp_wv;
        bit             pop_order;
        beat_t          bt;
        if (mon_en) begin
            // W path, evaluated on the pre-edge model state.
            pop_order = 1'b0;
            h = (order_q.size() > 0) ? order_q[0] : 0;
            exp_wv = (order_q.size() > 0) && dsp_WVALID_i[h];
            check("s_WVALID", s_WVALID_o, exp_wv);
            exp_rdy = '0;
            if (order_q.size() > 0) exp_rdy[h] = s_WREADY_i;
            check("dsp_WREADY", dsp_WREADY_o, exp_rdy);
            if (exp_wv && s_WREADY_i) begin
                if (sb_q.size() == 0) begin
                    check("w_beat_expected", 1, 0);
                end else begin
                    bt = sb_q.pop_front();
                    check("s_WDATA", s_WDATA_o, bt.data);
                    check("s_WLAST", s_WLAST_o, bt.last);
                    if (bt.last) pop_order = 1'b1;
                end
            end

            // AW path.
            req = dsp_AWVALID_i & ~dsp_AW_outst_full_i;
            found = 1'b0;
            g = 0;
            if (m_lock) begin
                found = 1'b1;
                g = m_lock_idx;
            end else begin
                for (int i = 0; i < MST; i++) begin
                    c = (m_ptr + i) % MST;
                    if (!found && req[c]) begin
                        found = 1'b1;
                        g = c;
                    end
                end
            end
            exp_awv = found && (order_q.size() < DEPTH);
            check("s_AWVALID", s_AWVALID_o, exp_awv);
            exp_rdy = '0;
            if (exp_awv) begin
                ti = aw_i[g];
                if (ti < NTX) begin
                    check("s_AWID", s_AWID_o, {g[0], tx_id[g][ti]});
                    check("s_AWADDR", s_AWADDR_o, tx_addr[g][ti]);
                    check("s_AWLEN", s_AWLEN_o, tx_len[g][ti]);
                    check("s_AWSIZE", s_AWSIZE_o, tx_size[g][ti]);
                    check("s_AWBURST", s_AWBURST_o, 2'b01);
                end
                exp_rdy[g] = s_AWREADY_i;
            end
            check("dsp_AWREADY", dsp_AWREADY_o, exp_rdy);

            // B path.
            m = int'(s_BID_i[XW-1]);
            exp_rdy = '0;
            exp_rdy[m] = s_BVALID_i;
            check("dsp_BVALID", dsp_BVALID_o, exp_rdy);
            check("s_BREADY", s_BREADY_o, dsp_BREADY_i[m]);
            check("dsp_BID", dsp_BID_o, {s_BID_i[IDW-1:0], s_BID_i[IDW-1:0]});
            check("dsp_BRESP", dsp_BRESP_o, {s_BRESP_i, s_BRESP_i});

            // Apply model updates.
            if (pop_order) void'(order_q.pop_front());
            if (exp_awv && s_AWREADY_i) begin
                ti = aw_i[g];
                for (int b = 0; b <= int'(tx_len[g][ti]); b++) begin
                    bt.data = tx_base[g][ti] + DW'(b);
                    bt.last = (b == int'(tx_len[g][ti]));
                    sb_q.push_back(bt);
                end
                order_q.push_back(g);
                m_ptr = (g + 1) % MST;
                m_lock = 1'b0;
            end else if (exp_awv) begin
                m_lock = 1'b1;
                m_lock_idx = g;
            end
        end
        aw_hs_seen = dsp_AWREADY_o & dsp_AWVALID_i;
        w_hs_seen  = dsp_WREADY_o & dsp_WVALID_i;
    end

    task automatic clear_inputs();
        dsp_AWID_i = '0; dsp_AWADDR_i = '0; dsp_AWBURST_i = {MST{2'b01}};
        dsp_AWLEN_i = '0; dsp_AWSIZE_i = '0; dsp_AWVALID_i = '0; dsp_AW_outst_full_i = '0;
        dsp_WDATA_i = '0; dsp_WLAST_i = '0; dsp_WVALID_i = '0; dsp_BREADY_i = '0;
        s_AWREADY_i = 1'b0; s_WREADY_i = 1'b0;
        s_BID_i = '0; s_BRESP_i = '0; s_BVALID_i = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        bit done;
        clear_inputs();

        // Reset state: outputs forced low even with requests and ready present.
        rst_n = 1'b0;
        dsp_AWVALID_i = 2'b11; s_AWREADY_i = 1'b1;
        dsp_WVALID_i = 2'b11;  s_WREADY_i = 1'b1;
        #3;
        check("rst_s_AWVALID", s_AWVALID_o, 0);
        check("rst_dsp_AWREADY", dsp_AWREADY_o, 0);
        check("rst_s_WVALID", s_WVALID_o, 0);
        check("rst_dsp_WREADY", dsp_WREADY_o, 0);

        // Both dispatchers requesting: grants alternate 0,1,0,1.
        do_reset();
        dsp_AWID_i[0 +: IDW] = 5'h0A;
        dsp_AWID_i[IDW +: IDW] = 5'h15;
        dsp_AWVALID_i = 2'b11; s_AWREADY_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("alt_s_AWID", s_AWID_o, (i % 2 == 0) ? {1'b0, 5'h0A} : {1'b1, 5'h15});
            check("alt_dsp_AWREADY", dsp_AWREADY_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            cycle();
        end

        // W ordering: master 1 (4 beats) accepted before master 0 (1 beat).
        do_reset();
        dsp_AWLEN_i[3 +: 3] = 3'd3;
        dsp_AWVALID_i = 2'b10; s_AWREADY_i = 1'b1;
        @(negedge clk);
        check("ord_grant1", s_AWID_o[XW-1], 1);
        cycle();
        dsp_AWVALID_i = 2'b01;
        @(negedge clk);
        check("ord_grant0", s_AWID_o[XW-1], 0);
        cycle();
        dsp_AWVALID_i = 2'b00; s_AWREADY_i = 1'b0;
        dsp_WVALID_i = 2'b11; s_WREADY_i = 1'b1;
        dsp_WDATA_i[0 +: DW] = 32'h2000; dsp_WLAST_i[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            dsp_WDATA_i[DW +: DW] = 32'h1000 + DW'(b);
            dsp_WLAST_i[1] = (b == 3);
            @(negedge clk);
            check("ord_m1_data", s_WDATA_o, 32'h1000 + b);
            check("ord_m1_last", s_WLAST_o, (b == 3));
            check("ord_m1_wready", dsp_WREADY_o, 2'b10);
            cycle();
        end
        @(negedge clk);
        check("ord_m0_data", s_WDATA_o, 32'h2000);
        check("ord_m0_wready", dsp_WREADY_o, 2'b01);
        cycle();
        @(negedge clk);
        check("ord_empty_wvalid", s_WVALID_o, 0);
        cycle();

        // Stall: grant and payload stay on master 0, then master 1 follows.
        do_reset();
        dsp_AWADDR_i[0 +: AW] = 32'hCAFE_0000;
        dsp_AWADDR_i[AW +: AW] = 32'hBEEF_0000;
        dsp_AWVALID_i = 2'b01; s_AWREADY_i = 1'b0;
        @(negedge clk);
        check("stall_awvalid", s_AWVALID_o, 1);
        cycle();
        dsp_AWVALID_i = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_grant", s_AWID_o[XW-1], 0);
            check("stall_addr", s_AWADDR_o, 32'hCAFE_0000);
            check("stall_awready", dsp_AWREADY_o, 0);
            cycle();
        end
        s_AWREADY_i = 1'b1;
        @(negedge clk);
        check("stall_release", dsp_AWREADY_o, 2'b01);
        cycle();
        dsp_AWVALID_i = 2'b10;
        @(negedge clk);
        check("stall_next_grant", s_AWID_o[XW-1], 1);
        check("stall_next_addr", s_AWADDR_o, 32'hBEEF_0000);
        cycle();

        // FIFO full: 8 accepted, 9th blocked even during a pop, then granted.
        do_reset();
        dsp_AWVALID_i = 2'b01; s_AWREADY_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("fill_awready", dsp_AWREADY_o, 2'b01);
            cycle();
        end
        dsp_WVALID_i = 2'b01; dsp_WLAST_i = 2'b01; s_WREADY_i = 1'b1;
        @(negedge clk);
        check("full_awvalid_during_pop", s_AWVALID_o, 0);
        check("full_pop_wlast", s_WLAST_o & s_WVALID_o, 1);
        cycle();
        dsp_WVALID_i = 2'b00;
        @(negedge clk);
        check("after_pop_awvalid", s_AWVALID_o, 1);
        check("after_pop_awready", dsp_AWREADY_o, 2'b01);
        cycle();
        dsp_AWVALID_i = 2'b00;

        // B routing.
        s_BID_i = 6'b1_00101; s_BRESP_i = 2'b10; s_BVALID_i = 1'b1; dsp_BREADY_i = 2'b10;
        #1;
        check("b_bvalid", dsp_BVALID_o, 2'b10);
        check("b_bid", dsp_BID_o, {5'd5, 5'd5});
        check("b_bresp", dsp_BRESP_o, 4'b1010);
        check("b_bready", s_BREADY_o, 1);
        dsp_BREADY_i = 2'b01;
        #1;
        check("b_bready_other", s_BREADY_o, 0);
        s_BID_i = 6'b0_00011;
        #1;
        check("b_bvalid_m0", dsp_BVALID_o, 2'b01);
        check("b_bready_m0", s_BREADY_o, 1);

        // Reset mid-burst with three entries queued and pointer at 1.
        do_reset();
        dsp_AWVALID_i = 2'b01; s_AWREADY_i = 1'b1;
        repeat (3) cycle();
        dsp_AWVALID_i = 2'b00;
        dsp_WVALID_i = 2'b01; dsp_WLAST_i = 2'b00; s_WREADY_i = 1'b1;
        @(negedge clk);
        check("mid_wvalid", s_WVALID_o, 1);
        #2;
        rst_n = 1'b0;
        dsp_AWVALID_i = 2'b11;
        #1;
        check("mid_rst_wvalid", s_WVALID_o, 0);
        check("mid_rst_wready", dsp_WREADY_o, 0);
        check("mid_rst_awvalid", s_AWVALID_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_wvalid", s_WVALID_o, 0);
        check("post_rst_awvalid", s_AWVALID_o, 1);
        check("post_rst_grant", s_AWID_o[XW-1], 0);

        // Randomized run against the reference model.
        for (int k = 0; k < MST; k++) begin
            for (int t = 0; t < NTX; t++) begin
                tx_id[k][t]   = IDW'($urandom);
                tx_addr[k][t] = $urandom;
                tx_len[k][t]  = 3'($urandom_range(0, 3));
                tx_size[k][t] = 3'($urandom_range(0, 2));
                tx_base[k][t] = $urandom & 32'hFFFF_FFF0;
            end
            aw_i[k] = 0; w_i[k] = 0; w_b[k] = 0;
        end
        do_reset();
        sb_q.delete(); order_q.delete();
        m_ptr = 0; m_lock = 1'b0; m_lock_idx = 0;
        @(negedge clk);
        mon_en = 1'b1;
        done = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            cycle();
            for (int k = 0; k < MST; k++) begin
                if (aw_hs_seen[k]) aw_i[k]++;
                if (w_hs_seen[k]) begin
                    if (w_b[k] == int'(tx_len[k][w_i[k]])) begin
                        w_i[k]++;
                        w_b[k] = 0;
                    end else begin
                        w_b[k]++;
                    end
                end
                if (!(dsp_AWVALID_i[k] && !aw_hs_seen[k])) begin
                    dsp_AWVALID_i[k] = (aw_i[k] < NTX) && ($urandom_range(0, 2) != 0);
                    if (aw_i[k] < NTX) begin
                        dsp_AWID_i[k*IDW +: IDW] = tx_id[k][aw_i[k]];
                        dsp_AWADDR_i[k*AW +: AW] = tx_addr[k][aw_i[k]];
                        dsp_AWLEN_i[k*3 +: 3]    = tx_len[k][aw_i[k]];
                        dsp_AWSIZE_i[k*3 +: 3]   = tx_size[k][aw_i[k]];
                    end
                end
                dsp_AW_outst_full_i[k] = ($urandom_range(0, 7) == 0);
                if (!(dsp_WVALID_i[k] && !w_hs_seen[k])) begin
                    dsp_WVALID_i[k] = (w_i[k] < NTX) && ($urandom_range(0, 3) != 0);
                    if (w_i[k] < NTX) begin
                        dsp_WDATA_i[k*DW +: DW] = tx_base[k][w_i[k]] + DW'(w_b[k]);
                        dsp_WLAST_i[k] = (w_b[k] == int'(tx_len[k][w_i[k]]));
                    end
                end
            end
            s_AWREADY_i  = ($urandom_range(0, 2) != 0);
            s_WREADY_i   = ($urandom_range(0, 3) != 0);
            s_BID_i      = XW'($urandom);
            s_BRESP_i    = 2'($urandom);
            s_BVALID_i   = 1'($urandom);
            dsp_BREADY_i = MST'($urandom);
            done = (w_i[0] == NTX) && (w_i[1] == NTX);
        end
        mon_en = 1'b0;
        check("random_complete", done, 1);
        check("random_sb_empty", sb_q.size(), 0);
        check("random_order_empty", order_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sa_write_channel.md
SA_WRITE_CHANNEL -- requirements
Module: sa_write_channel

Interface
REQ-001 SHALL have parameter MST_AMT, default 2: number of dispatchers (masters) arbitrated onto one slave.
REQ-002 SHALL have parameter OUTSTANDING_AMT, default 8: depth of the W-order FIFO, a power of two.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: WDATA width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32: AWADDR width.
REQ-005 SHALL have parameter TRANS_MST_ID_W, default 5: master transaction ID width.
REQ-006 SHALL have parameters TRANS_BURST_W=2, TRANS_DATA_LEN_W=3, TRANS_DATA_SIZE_W=3 and TRANS_WR_RESP_W=2: AWBURST, AWLEN, AWSIZE and BRESP widths.
REQ-007 SHALL have parameter MST_ID_W, default $clog2(MST_AMT): master index width.
REQ-008 SHALL have the following ports:
- ACLK_i, input, 1: the single clock.
- ARESETn_i, input, 1: reset, asynchronous and active-low.
- dsp_AWID_i, dsp_AWADDR_i, dsp_AWBURST_i, dsp_AWLEN_i, dsp_AWSIZE_i, input, field width x MST_AMT: per-dispatcher AW payload, dispatcher k in slice k.
- dsp_AWVALID_i, input, MST_AMT: AW valid per dispatcher.
- dsp_AW_outst_full_i, input, MST_AMT: dispatcher outstanding queue full.
- dsp_AWREADY_o, output, MST_AMT: AW ready per dispatcher.
- dsp_WDATA_i, input, DATA_WIDTH x MST_AMT; dsp_WLAST_i, input, MST_AMT: per-dispatcher W payload.
- dsp_WVALID_i, input, MST_AMT; dsp_WREADY_o, output, MST_AMT: W handshake per dispatcher.
- dsp_BID_o, output, TRANS_MST_ID_W x MST_AMT; dsp_BRESP_o, output, TRANS_WR_RESP_W x MST_AMT: B payload, broadcast to every slice.
- dsp_BVALID_o, output, MST_AMT; dsp_BREADY_i, input, MST_AMT: B handshake per dispatcher.
- s_AWID_o, output, TRANS_MST_ID_W+MST_ID_W: extended ID, {grant index, AWID}.
- s_AWADDR_o, s_AWBURST_o, s_AWLEN_o, s_AWSIZE_o, output, field widths: granted AW payload.
- s_AWVALID_o, output, 1; s_AWREADY_i, input, 1: slave AW handshake.
- s_WDATA_o, output, DATA_WIDTH; s_WLAST_o, output, 1; s_WVALID_o, output, 1; s_WREADY_i, input, 1: slave W channel.
- s_BID_i, input, TRANS_MST_ID_W+MST_ID_W; s_BRESP_i, input, TRANS_WR_RESP_W; s_BVALID_i, input, 1; s_BREADY_o, output, 1: slave B channel.

Function
REQ-009 SHALL treat dispatcher k as requesting when dsp_AWVALID_i[k]=1 and dsp_AW_outst_full_i[k]=0.
REQ-010 SHALL arbitrate AW round-robin:
- The highest priority goes to the index after the last handshaken grant, mod MST_AMT.
- Before the first grant, index 0 has the highest priority.
REQ-011 SHALL lock the grant once s_AWVALID_o=1 and keep payload and grant stable until s_AWVALID_o&s_AWREADY_i, per AXI stability rules.
REQ-012 SHALL drive s_AWVALID_o=1 only when a request exists and the W-order FIFO is not full; when the FIFO is full it SHALL be 0 even if a pop occurs in the same cycle.
REQ-013 SHALL set dsp_AWREADY_o[g]=s_AWREADY_i&s_AWVALID_o for granted g, and 0 for all other indices; all signals are combinational and there is zero-cycle latency.
REQ-014 SHALL push g into the W-order FIFO on each AW handshake.
REQ-015 SHALL advance the round-robin pointer to g+1 mod MST_AMT on each AW handshake.
REQ-016 SHALL route W from head index h of the FIFO:
- s_WVALID_o = !empty & dsp_WVALID_i[h].
- s_WDATA_o and s_WLAST_o come from slice h.
- dsp_WREADY_o[h] = !empty & s_WREADY_i; all other dsp_WREADY_o bits are 0.
REQ-017 SHALL hold all W outputs low while the FIFO is empty, so W never precedes its AW.
REQ-018 SHALL pop the FIFO on s_WVALID_o&s_WREADY_i&s_WLAST_o.
REQ-019 SHALL perform simultaneous push and pop in the same cycle, leaving the count unchanged.
REQ-020 SHALL wrap FIFO pointers mod OUTSTANDING_AMT and track full/empty with an extra pointer bit.
REQ-021 SHALL route B by m=s_BID_i[MST_ID_W+TRANS_MST_ID_W-1:TRANS_MST_ID_W]:
- dsp_BVALID_o[m]=s_BVALID_i; all other dsp_BVALID_o bits are 0.
- s_BREADY_o=dsp_BREADY_i[m].
- Every dsp_BID_o slice = s_BID_i[TRANS_MST_ID_W-1:0]; every dsp_BRESP_o slice = s_BRESP_i.
REQ-022 SHALL treat an m value of MST_AMT or above (non-power-of-two MST_AMT) as out of range: dsp_BVALID_o=0 and s_BREADY_o=1, so the response is dropped.

Reset
REQ-023 SHALL, while ARESETn_i=0, asynchronously:
- Clear the FIFO to empty and clear the grant lock.
- Set the round-robin pointer to 0.
- Force s_AWVALID_o, s_WVALID_o, dsp_AWREADY_o and dsp_WREADY_o to 0.
Assertion mid-burst discards all queued W order.

Verification
REQ-024 SHALL pass these directed scenarios:
- Reset, then dsp_AWVALID_i=2'b11 held and s_AWREADY_i=1 -> grants alternate 0,1,0,1; s_AWID_o[5]=0,1,0,1.
- Dispatcher 1 AW (LEN=3), then dispatcher 0 AW; both stream W -> slave sees 4 beats from 1, then beats from 0; WREADY stays 0 to 0 until WLAST of 1.
- s_AWREADY_i=0 for 3 cycles while dispatcher 0 holds valid and 1 raises valid -> grant stays 0 and payload is stable; 1 is granted next.
- Push 8 AWs with no W -> 9th: s_AWVALID_o=0; pop via WLAST in the same cycle still blocks; the next cycle grants.
- s_BID_i=6'b1_00101, s_BVALID_i=1, dsp_BREADY_i=2'b10 -> dsp_BVALID_o=2'b10, BID slices=5, s_BREADY_o=1.
- ARESETn_i low mid-W-burst with FIFO count 3 -> the FIFO is immediately empty, s_WVALID_o=0, and the pointer is 0.
